// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state/owner types, access-size codes and lane helpers
// used by mem_port_arbiter and mem_lane_align.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    ERRRESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Byte enables for an access of the given size at the given byte offset.
  function automatic logic [3:0] calc_be(input logic [1:0] size, input logic [1:0] addrLo);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << addrLo;
      SZ_HALF: be = addrLo[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // True for accesses the memory port must never see (bad alignment or size 3).
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addrLo);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = addrLo[0];
      SZ_WORD: mis = (addrLo != 2'b00);
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational byte-lane logic. Request side produces byte
// enables and lane-replicated write data; response side extracts the
// addressed lane(s) from the read word and zero-extends them.
module mem_lane_align
  import mem_arb_pkg::*;
(
  input  logic [1:0]  reqSize,
  input  logic [1:0]  reqAddrLo,
  input  logic [31:0] reqWdata,
  output logic [3:0]  reqBe,
  output logic [31:0] reqWdataRep,
  input  logic [1:0]  rspSize,
  input  logic [1:0]  rspAddrLo,
  input  logic [31:0] rspData,
  output logic [31:0] rspDataExt
);

  logic [7:0] laneByte [4];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : gLane
      assign laneByte[gi] = rspData[8*gi +: 8];
    end
  endgenerate

  assign reqBe = calc_be(reqSize, reqAddrLo);

  // Replicate the right-justified store data across every lane it may land on.
  always_comb begin
    reqWdataRep = reqWdata;
    case (reqSize)
      SZ_BYTE: reqWdataRep = {4{reqWdata[7:0]}};
      SZ_HALF: reqWdataRep = {2{reqWdata[15:0]}};
      default: reqWdataRep = reqWdata;
    endcase
  end

  // Pick the addressed lane(s) of the read word and right-justify them.
  always_comb begin
    rspDataExt = '0;
    case (rspSize)
      SZ_BYTE: rspDataExt = {24'h0, laneByte[rspAddrLo]};
      SZ_HALF: rspDataExt = rspAddrLo[1] ? {16'h0, laneByte[3], laneByte[2]}
                                         : {16'h0, laneByte[1], laneByte[0]};
      default: rspDataExt = rspData;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch (IF) and
// load/store (LS). Grants are combinational in IDLE, the access is latched on
// grant, strobes run until MEM_ACK or the MAX_WAIT timeout, and the owner gets
// a one-cycle RVALID pulse with ERR.
// Build option: define ARB_RR_EN for round-robin arbitration on collisions;
// otherwise LS always wins and no pointer register exists.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic        ACLK,
  input  logic        RESET,
  input  logic        IF_REQ,
  input  logic [31:0] IF_ADDR,
  output logic        IF_GNT,
  output logic        IF_RVALID,
  output logic [31:0] IF_RDATA,
  output logic        IF_ERR,
  input  logic        LS_REQ,
  input  logic        LS_WE,
  input  logic [1:0]  LS_SIZE,
  input  logic [31:0] LS_ADDR,
  input  logic [31:0] LS_WDATA,
  output logic        LS_GNT,
  output logic        LS_RVALID,
  output logic [31:0] LS_RDATA,
  output logic        LS_ERR,
  output logic [31:0] ADDR,
  output logic [31:0] DATA_O,
  output logic [3:0]  BE,
  output logic        WRSTB,
  output logic        RDSTB,
  input  logic [31:0] DATA_I,
  input  logic        MEM_ACK
);

  state_t      stateReg, stateNext;
  logic [7:0]  waitReg, waitNext;
  logic        readyReg;
  owner_t      ownerReg;
  logic        weReg;
  logic [1:0]  sizeReg;
  logic        ifGnt, lsGnt, anyGnt, preferLs;
  logic        done, doneErr;
  logic [31:0] selAddr;
  logic [1:0]  selSize;
  logic        selMis;
  logic [3:0]  laneBe;
  logic [31:0] laneWdata, laneRdata;

`ifdef ARB_RR_EN
  owner_t ptrReg;

  assign preferLs = (ptrReg == OWN_LS);

  // Hand priority to whichever requester did not get the last grant.
  always_ff @(posedge ACLK) begin
    if (RESET) begin
      ptrReg <= OWN_LS;
    end else if (anyGnt) begin
      ptrReg <= lsGnt ? OWN_IF : OWN_LS;
    end
  end
`else
  assign preferLs = 1'b1;
`endif

  // Grant only from IDLE once out of reset; a collision goes to the preferred side.
  always_comb begin
    ifGnt = 1'b0;
    lsGnt = 1'b0;
    if (readyReg && !RESET && stateReg == IDLE) begin
      if (IF_REQ && LS_REQ) begin
        lsGnt = preferLs;
        ifGnt = !preferLs;
      end else begin
        lsGnt = LS_REQ;
        ifGnt = IF_REQ;
      end
    end
  end

  assign anyGnt  = ifGnt | lsGnt;
  assign IF_GNT  = ifGnt;
  assign LS_GNT  = lsGnt;
  assign selAddr = lsGnt ? LS_ADDR : IF_ADDR;
  assign selSize = lsGnt ? LS_SIZE : SZ_WORD;
  assign selMis  = is_misaligned(selSize, selAddr[1:0]);

  assign WRSTB = !RESET && (stateReg == BUSY) && weReg;
  assign RDSTB = !RESET && (stateReg == BUSY) && !weReg;

  mem_lane_align uAlign (
    .reqSize     (selSize),
    .reqAddrLo   (selAddr[1:0]),
    .reqWdata    (LS_WDATA),
    .reqBe       (laneBe),
    .reqWdataRep (laneWdata),
    .rspSize     (sizeReg),
    .rspAddrLo   (ADDR[1:0]),
    .rspData     (DATA_I),
    .rspDataExt  (laneRdata)
  );

  // Next state, wait counter and completion decode.
  always_comb begin
    stateNext = stateReg;
    waitNext  = waitReg;
    done      = 1'b0;
    doneErr   = 1'b0;
    case (stateReg)
      IDLE: begin
        if (anyGnt) begin
          stateNext = selMis ? ERRRESP : BUSY;
          waitNext  = '0;
        end
      end
      BUSY: begin
        if (MEM_ACK) begin
          stateNext = IDLE;
          done      = 1'b1;
        end else begin
          waitNext = waitReg + 8'd1;
          if (waitReg + 8'd1 == 8'(MAX_WAIT)) begin
            stateNext = IDLE;
            done      = 1'b1;
            doneErr   = 1'b1;
          end
        end
      end
      ERRRESP: begin
        stateNext = IDLE;
        done      = 1'b1;
        doneErr   = 1'b1;
      end
      default: stateNext = IDLE;
    endcase
  end

  // State, wait counter and the post-reset readiness flag.
  always_ff @(posedge ACLK) begin
    if (RESET) begin
      stateReg <= IDLE;
      waitReg  <= '0;
      readyReg <= 1'b0;
    end else begin
      stateReg <= stateNext;
      waitReg  <= waitNext;
      readyReg <= 1'b1;
    end
  end

  // Latch the granted access and produce the owner's response pulse.
  always_ff @(posedge ACLK) begin
    if (RESET) begin
      ADDR      <= '0;
      BE        <= '0;
      DATA_O    <= '0;
      weReg     <= 1'b0;
      sizeReg   <= SZ_BYTE;
      ownerReg  <= OWN_IF;
      IF_RVALID <= 1'b0;
      IF_ERR    <= 1'b0;
      IF_RDATA  <= '0;
      LS_RVALID <= 1'b0;
      LS_ERR    <= 1'b0;
      LS_RDATA  <= '0;
    end else begin
      IF_RVALID <= done && (ownerReg == OWN_IF);
      IF_ERR    <= done && doneErr && (ownerReg == OWN_IF);
      IF_RDATA  <= (done && !doneErr && ownerReg == OWN_IF) ? DATA_I : '0;
      LS_RVALID <= done && (ownerReg == OWN_LS);
      LS_ERR    <= done && doneErr && (ownerReg == OWN_LS);
      LS_RDATA  <= (done && !doneErr && !weReg && ownerReg == OWN_LS) ? laneRdata : '0;
      if (anyGnt) begin
        ADDR     <= selAddr;
        BE       <= lsGnt ? laneBe : 4'b0000;
        DATA_O   <= (lsGnt && LS_WE) ? laneWdata : '0;
        weReg    <= lsGnt && LS_WE;
        sizeReg  <= selSize;
        ownerReg <= lsGnt ? OWN_LS : OWN_IF;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized and directed transactions checked against a
// transaction-level model of the arbiter's rules.
module tb_mem_port_arbiter;

  localparam int MAX_WAIT = 15;
`ifdef ARB_RR_EN
  localparam bit RR_BUILD = 1'b1;
`else
  localparam bit RR_BUILD = 1'b0;
`endif

  logic        ACLK = 1'b0;
  logic        RESET;
  logic        IF_REQ, IF_GNT, IF_RVALID, IF_ERR;
  logic [31:0] IF_ADDR, IF_RDATA;
  logic        LS_REQ, LS_WE, LS_GNT, LS_RVALID, LS_ERR;
  logic [1:0]  LS_SIZE;
  logic [31:0] LS_ADDR, LS_WDATA, LS_RDATA;
  logic [31:0] ADDR, DATA_O, DATA_I;
  logic [3:0]  BE;
  logic        WRSTB, RDSTB, MEM_ACK;

  int testCount = 0;
  int failCount = 0;
  int txnCount  = 0;

  always #5 ACLK = ~ACLK;

  mem_port_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .ACLK(ACLK), .RESET(RESET),
    .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR), .IF_GNT(IF_GNT), .IF_RVALID(IF_RVALID),
    .IF_RDATA(IF_RDATA), .IF_ERR(IF_ERR),
    .LS_REQ(LS_REQ), .LS_WE(LS_WE), .LS_SIZE(LS_SIZE), .LS_ADDR(LS_ADDR),
    .LS_WDATA(LS_WDATA), .LS_GNT(LS_GNT), .LS_RVALID(LS_RVALID),
    .LS_RDATA(LS_RDATA), .LS_ERR(LS_ERR),
    .ADDR(ADDR), .DATA_O(DATA_O), .BE(BE), .WRSTB(WRSTB), .RDSTB(RDSTB),
    .DATA_I(DATA_I), .MEM_ACK(MEM_ACK)
  );

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---- reference model: plain arithmetic on the access rules ----
  function automatic bit modelMis(input logic [1:0] size, input logic [31:0] addr);
    int n;
    if (size == 2'd3) return 1'b1;
    n = 1 << size;
    return (addr % n) != 0;
  endfunction

  function automatic logic [3:0] modelBe(input logic [1:0] size, input logic [31:0] addr);
    int n;
    int m;
    n = 1 << size;
    m = ((1 << n) - 1) << addr[1:0];
    return m[3:0];
  endfunction

  function automatic logic [31:0] modelDo(input logic [1:0] size, input logic [31:0] wdata);
    int n;
    logic [31:0] r;
    n = 1 << size;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wdata[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] modelRd(input logic [1:0] size, input logic [31:0] addr,
                                          input logic [31:0] rdata);
    int n;
    int off;
    logic [31:0] sh;
    n   = 1 << size;
    off = int'(addr[1:0]);
    sh  = rdata >> (8 * off);
    if (n == 4) return sh;
    return sh & ((32'h1 << (8 * n)) - 32'h1);
  endfunction

  task automatic idleInputs();
    IF_REQ = 1'b0; IF_ADDR = '0;
    LS_REQ = 1'b0; LS_WE = 1'b0; LS_SIZE = 2'd0; LS_ADDR = '0; LS_WDATA = '0;
    DATA_I = '0; MEM_ACK = 1'b0;
  endtask

  task automatic doReset();
    @(negedge ACLK);
    RESET = 1'b1;
    idleInputs();
    repeat (3) @(negedge ACLK);
    #1;
    checkEq("rst_ctl", {IF_GNT, IF_RVALID, IF_ERR, LS_GNT, LS_RVALID, LS_ERR, WRSTB, RDSTB}, 8'h00);
    checkEq("rst_addr", ADDR, 32'h0);
    checkEq("rst_be", BE, 4'h0);
    @(negedge ACLK);
    RESET = 1'b0;
    @(negedge ACLK);
  endtask

  // One request on an idle arbiter; memory acks after `waits` wait states.
  task automatic runTxn(input bit isLs, input bit we, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int waits);
    bit mis, expErr, wr;
    int nStrobe, rvC;
    logic [1:0] strbOn, rvOn;
    logic [3:0] expBe;
    logic [31:0] expDo, expRd;
    mis     = isLs ? modelMis(size, addr) : (addr % 4 != 0);
    wr      = isLs && we;
    nStrobe = mis ? 0 : ((waits >= MAX_WAIT) ? MAX_WAIT : waits + 1);
    rvC     = mis ? 2 : nStrobe + 1;
    expErr  = mis || (waits >= MAX_WAIT);
    strbOn  = wr ? 2'b10 : 2'b01;
    rvOn    = isLs ? 2'b01 : 2'b10;
    expBe   = isLs ? modelBe(size, addr) : 4'h0;
    expDo   = modelDo(size, wdata);
    expRd   = (expErr || wr) ? 32'h0 : (isLs ? modelRd(size, addr, rdata) : rdata);
    txnCount++;
    $display("[TB] txn %0d ls=%0d we=%0d size=%0d addr=%h wdata=%h rdata=%h waits=%0d",
             txnCount, isLs, we, size, addr, wdata, rdata, waits);
    @(negedge ACLK);
    if (isLs) begin
      LS_REQ = 1'b1; LS_WE = we; LS_SIZE = size; LS_ADDR = addr; LS_WDATA = wdata;
    end else begin
      IF_REQ = 1'b1; IF_ADDR = addr;
    end
    DATA_I = rdata;
    #1;
    checkEq("gnt", {IF_GNT, LS_GNT}, rvOn);
    for (int c = 1; c <= rvC + 1; c++) begin
      @(negedge ACLK);
      IF_REQ  = 1'b0;
      LS_REQ  = 1'b0;
      MEM_ACK = !mis && ((c == waits + 1) || (waits >= MAX_WAIT && c == rvC));
      #1;
      checkEq("strobe", {WRSTB, RDSTB}, (c <= nStrobe) ? strbOn : 2'b00);
      checkEq("rvalid", {IF_RVALID, LS_RVALID}, (c == rvC) ? rvOn : 2'b00);
      if (c <= nStrobe) begin
        checkEq("addr", ADDR, addr);
        checkEq("be", BE, expBe);
        if (wr) checkEq("data_o", DATA_O, expDo);
      end
      if (c == rvC) begin
        checkEq("err", isLs ? LS_ERR : IF_ERR, expErr);
        checkEq("rdata", isLs ? LS_RDATA : IF_RDATA, expRd);
      end
    end
    MEM_ACK = 1'b0;
  endtask

  // Both requesters collide, then LS re-requests in its own RVALID cycle.
  task automatic runCollision();
    bit win2Ls;
    win2Ls = !RR_BUILD;
    $display("[TB] txn collision rr=%0d", RR_BUILD);
    @(negedge ACLK);
    IF_REQ = 1'b1; IF_ADDR = 32'h300;
    LS_REQ = 1'b1; LS_WE = 1'b0; LS_SIZE = 2'd2; LS_ADDR = 32'h400;
    #1;
    checkEq("col1_gnt", {IF_GNT, LS_GNT}, 2'b01);
    @(negedge ACLK);
    LS_REQ = 1'b0; MEM_ACK = 1'b1; DATA_I = 32'h11111111;
    #1;
    checkEq("col1_strb", {WRSTB, RDSTB}, 2'b01);
    checkEq("col1_addr", ADDR, 32'h400);
    checkEq("col1_busy_gnt", {IF_GNT, LS_GNT}, 2'b00);
    @(negedge ACLK);
    MEM_ACK = 1'b0; LS_REQ = 1'b1; LS_ADDR = 32'h500;
    #1;
    checkEq("col1_rv", {IF_RVALID, LS_RVALID}, 2'b01);
    checkEq("col1_rdata", LS_RDATA, 32'h11111111);
    checkEq("col2_gnt", {IF_GNT, LS_GNT}, win2Ls ? 2'b01 : 2'b10);
    @(negedge ACLK);
    if (win2Ls) LS_REQ = 1'b0;
    else        IF_REQ = 1'b0;
    MEM_ACK = 1'b1; DATA_I = 32'h22222222;
    #1;
    checkEq("col2_addr", ADDR, win2Ls ? 32'h500 : 32'h300);
    @(negedge ACLK);
    MEM_ACK = 1'b0;
    #1;
    checkEq("col2_rv", {IF_RVALID, LS_RVALID}, win2Ls ? 2'b01 : 2'b10);
    checkEq("col2_rdata", win2Ls ? LS_RDATA : IF_RDATA, 32'h22222222);
    checkEq("col3_gnt", {IF_GNT, LS_GNT}, win2Ls ? 2'b10 : 2'b01);
    @(negedge ACLK);
    IF_REQ = 1'b0; LS_REQ = 1'b0; MEM_ACK = 1'b1; DATA_I = 32'h33333333;
    #1;
    checkEq("col3_addr", ADDR, win2Ls ? 32'h300 : 32'h500);
    @(negedge ACLK);
    MEM_ACK = 1'b0;
    #1;
    checkEq("col3_rv", {IF_RVALID, LS_RVALID}, win2Ls ? 2'b10 : 2'b01);
    checkEq("col3_rdata", win2Ls ? IF_RDATA : LS_RDATA, 32'h33333333);
  endtask

  // Reset lands while a load is waiting on memory: the access vanishes.
  task automatic runResetMidBusy();
    $display("[TB] txn reset-mid-busy");
    @(negedge ACLK);
    LS_REQ = 1'b1; LS_WE = 1'b0; LS_SIZE = 2'd2; LS_ADDR = 32'h40;
    #1;
    checkEq("rmb_gnt", LS_GNT, 1'b1);
    for (int c = 0; c < 2; c++) begin
      @(negedge ACLK);
      LS_REQ = 1'b0;
      #1;
      checkEq("rmb_strb", RDSTB, 1'b1);
    end
    @(negedge ACLK);
    RESET = 1'b1;
    @(negedge ACLK);
    RESET = 1'b0;
    #1;
    checkEq("rmb_ctl", {IF_GNT, IF_RVALID, IF_ERR, LS_GNT, LS_RVALID, LS_ERR, WRSTB, RDSTB}, 8'h00);
    checkEq("rmb_addr", ADDR, 32'h0);
    checkEq("rmb_be", BE, 4'h0);
    checkEq("rmb_lsrd", LS_RDATA, 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge ACLK);
      #1;
      checkEq("rmb_quiet", {LS_RVALID, IF_RVALID, WRSTB, RDSTB}, 4'h0);
    end
  endtask

  initial begin
    bit isLs, we;
    logic [1:0] size;
    logic [31:0] addr;
    int r, waits;
    RESET = 1'b1;
    idleInputs();
    doReset();
    // directed cases
    runTxn(1'b0, 1'b0, 2'd2, 32'h0000_0100, 32'h0, 32'h00A0_0093, 0);
    runTxn(1'b1, 1'b1, 2'd0, 32'h0000_0203, 32'h0000_005A, 32'hDEAD_BEEF, 3);
    runTxn(1'b1, 1'b0, 2'd1, 32'h0000_0102, 32'h0, 32'hBEEF_1234, 0);
    runTxn(1'b1, 1'b0, 2'd2, 32'h0000_0101, 32'h0, 32'h1234_5678, 0);
    runTxn(1'b1, 1'b0, 2'd2, 32'h0000_0400, 32'h0, 32'hCAFE_F00D, MAX_WAIT + 4);
    runTxn(1'b0, 1'b0, 2'd2, 32'h0000_0802, 32'h0, 32'h0BAD_0BAD, 0);
    runTxn(1'b1, 1'b1, 2'd3, 32'h0000_0010, 32'h1, 32'h0, 2);
    // random cases
    for (int i = 0; i < 40; i++) begin
      isLs = ($urandom_range(0, 2) != 0);
      we   = $urandom_range(0, 1) == 1;
      size = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      addr = $urandom;
      if (!isLs && $urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
      r = $urandom_range(0, 9);
      waits = (r < 7) ? $urandom_range(0, 3) : ((r < 9) ? $urandom_range(MAX_WAIT - 2, MAX_WAIT + 1) : 0);
      runTxn(isLs, we, size, addr, $urandom, $urandom, waits);
    end
    doReset();
    runCollision();
    runResetMidBusy();
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
